// File: rtl/flip_flop.sv
// Falling-edge D register pipeline with synchronous active-low clear and valid tracking.
// Optional clock enable input 'ce' is present when FLIP_FLOP_CE_EN is defined.
module flip_flop #(
  parameter int unsigned          WIDTH       = 1,
  parameter int unsigned          STAGES      = 1,
  parameter logic [WIDTH-1:0]     RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             clr,
`ifdef FLIP_FLOP_CE_EN
  input  logic             ce,
`endif
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             vld
);

  logic [WIDTH-1:0]  stage_r [STAGES];
  logic [STAGES-1:0] valid_r;
  logic              adv_s;

`ifdef FLIP_FLOP_CE_EN
  assign adv_s = ce;
`else
  assign adv_s = 1'b1;
`endif

  // Data and valid pipelines; clear wins over enable, enable low holds every stage.
  always_ff @(negedge clk) begin
    if (!clr) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        stage_r[i] <= RESET_VALUE;
      end
      valid_r <= {STAGES{1'b0}};
    end else if (adv_s) begin
      stage_r[0] <= d;
      valid_r[0] <= 1'b1;
      for (int i = 1; i < int'(STAGES); i++) begin
        stage_r[i] <= stage_r[i-1];
        valid_r[i] <= valid_r[i-1];
      end
    end else begin
      for (int i = 0; i < int'(STAGES); i++) begin
        stage_r[i] <= stage_r[i];
      end
      valid_r <= valid_r;
    end
  end

  assign q   = stage_r[STAGES-1];
  assign vld = valid_r[STAGES-1];

endmodule

// File: tb/tb_flip_flop.sv
// Self-checking bench: a 1-bit/1-stage instance and an 8-bit/3-stage instance
// checked against a queue-based history model of accepted samples.
module tb_flip_flop;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       ce  = 1'b1;
  logic       d1  = 1'b0;
  logic [7:0] d8  = 8'h00;
  logic       q1, vld1, vld8;
  logic [7:0] q8;

  int compared   = 0;
  int mismatched = 0;
  bit inited     = 1'b0;

`ifdef FLIP_FLOP_CE_EN
  localparam bit HAS_CE = 1'b1;
`else
  localparam bit HAS_CE = 1'b0;
`endif

  // Model: recent samples accepted since the last clear, newest at the back.
  logic       h1 [$];
  logic [7:0] h8 [$];

  always #10 clk = ~clk;

  flip_flop dut1 (
    .clk(clk), .clr(clr),
`ifdef FLIP_FLOP_CE_EN
    .ce(ce),
`endif
    .d(d1), .q(q1), .vld(vld1)
  );

  flip_flop #(.WIDTH(8), .STAGES(3), .RESET_VALUE(8'hA5)) dut8 (
    .clk(clk), .clr(clr),
`ifdef FLIP_FLOP_CE_EN
    .ce(ce),
`endif
    .d(d8), .q(q8), .vld(vld8)
  );

  function automatic logic [7:0] eq1();
    return (h1.size() >= 1) ? {7'b0, h1[h1.size()-1]} : 8'h00;
  endfunction
  function automatic logic [7:0] ev1();
    return (h1.size() >= 1) ? 8'h01 : 8'h00;
  endfunction
  function automatic logic [7:0] eq8();
    return (h8.size() >= 3) ? h8[h8.size()-3] : 8'hA5;
  endfunction
  function automatic logic [7:0] ev8();
    return (h8.size() >= 3) ? 8'h01 : 8'h00;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_q1"},   {7'b0, q1},   eq1());
    chk({tag, "_vld1"}, {7'b0, vld1}, ev1());
    chk({tag, "_q8"},   q8,           eq8());
    chk({tag, "_vld8"}, {7'b0, vld8}, ev8());
  endtask

  // One falling-edge cycle: inputs change mid-cycle, outputs checked on both sides.
  task automatic step(input logic c, input logic dd1, input logic [7:0] dd8, input logic cc);
    @(posedge clk); #1;
    if (inited) check_all("rise");
    #4;
    clr = c; d1 = dd1; d8 = dd8; ce = cc;
    #3;
    if (inited) check_all("midcycle");
    @(negedge clk);
    if (!clr) begin
      h1.delete();
      h8.delete();
    end else if (!HAS_CE || ce) begin
      h1.push_back(d1);
      h8.push_back(d8);
      if (h1.size() > 1) void'(h1.pop_front());
      if (h8.size() > 3) void'(h8.pop_front());
    end
    inited = 1'b1;
    #1;
    check_all("fall");
  endtask

  initial begin
    // Clear, then capture pattern 1/0/1 and 11/22/33.
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("clear_q8_const", q8, 8'hA5);
    step(1'b1, 1'b1, 8'h11, 1'b1);
    chk("cap_q1_const", {7'b0, q1}, 8'h01);
    step(1'b1, 1'b0, 8'h22, 1'b1);
    chk("lat_vld8_low", {7'b0, vld8}, 8'h00);
    step(1'b1, 1'b1, 8'h33, 1'b1);
    chk("lat_q8_first", q8, 8'h11);
    step(1'b1, 1'b1, 8'h44, 1'b1);
    chk("lat_q8_second", q8, 8'h22);
    // Mid-pipeline clear with d=1 present.
    step(1'b0, 1'b1, 8'h55, 1'b1);
    chk("midclr_q1", {7'b0, q1}, 8'h00);
    chk("midclr_q8", q8, 8'hA5);
    step(1'b1, 1'b1, 8'h66, 1'b1);
    step(1'b1, 1'b0, 8'h77, 1'b1);
    chk("refill_vld8_low", {7'b0, vld8}, 8'h00);
    step(1'b1, 1'b1, 8'h88, 1'b1);
    chk("refill_vld8_high", {7'b0, vld8}, 8'h01);
    chk("refill_q8", q8, 8'h66);
`ifdef FLIP_FLOP_CE_EN
    step(1'b1, 1'b0, 8'h99, 1'b0);
    step(1'b1, 1'b1, 8'hAA, 1'b0);
    chk("ce_hold_q8", q8, 8'h66);
    step(1'b0, 1'b1, 8'hBB, 1'b0);
    chk("ce_clr_q8", q8, 8'hA5);
`endif
    // Randomized phase.
    for (int n = 0; n < 300; n++) begin
      step(($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0,
           1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)),
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
